pause_arbiter: RTL and testbench

- Central pause controller and work-RAM access arbiter for the arcade core.
- Merges three pause sources into one core pause:
  - user pause toggle
  - OSD-open pause, when enabled
  - hiscore save/restore requests
- Grants the hiscore engine the shared work-RAM port only after the CPU is paused, a settle window has elapsed, and the frame is in vertical blank.
- Also generates the screen-dim flag after a long user pause.
- Sits between hps_io/joystick decode, the hiscore module and the game core.

---
 rtl/pause_arbiter.sv | 140 ++++++++++++++
 tb/tb_pause_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pause_arbiter.sv
// pause_arbiter
// Merges the user toggle, OSD and hiscore pause sources into one core pause,
// hands the shared work-RAM port to the hiscore engine once the CPU is
// safely stopped inside vertical blank, and dims the screen after a long
// user pause.
module pause_arbiter #(
  parameter int unsigned DIM_CYCLES    = 120000000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic user_pause,
  input  logic osd_open,
  input  logic osd_pause_en,
  input  logic vblank,
  input  logic hs_req,
  output logic hs_grant,
  output logic ram_sel,
  output logic pause,
  output logic dim
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [27:0] DIM_LIMIT   = 28'(DIM_CYCLES);
  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state_r;
  logic        pause_toggle_r;
  logic        user_pause_d_r;
  logic [27:0] dim_cnt_r;
  logic [3:0]  settle_cnt_r;
  logic        hs_grant_r;
  logic        ram_sel_r;
  logic        dim_r;

  logic        btn_rise_s;
  logic        osd_pause_s;

  assign btn_rise_s  = user_pause & ~user_pause_d_r;
  assign osd_pause_s = osd_open & osd_pause_en;

  // Core pause is combinational so the OSD can freeze the core immediately;
  // any non-RUN arbiter state keeps the CPU stopped.
  assign pause    = pause_toggle_r | osd_pause_s | (state_r != ST_RUN);
  assign hs_grant = hs_grant_r;
  assign ram_sel  = ram_sel_r;
  assign dim      = dim_r;

  // Button edge detect: each press flips the user pause exactly once.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      user_pause_d_r <= 1'b0;
      pause_toggle_r <= 1'b0;
    end else begin
      user_pause_d_r <= user_pause;
      if (btn_rise_s) begin
        pause_toggle_r <= ~pause_toggle_r;
      end
    end
  end

  // Dim timer: counts only user-pause time, saturates so it never wraps.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dim_cnt_r <= 28'd0;
      dim_r     <= 1'b0;
    end else begin
      dim_r <= pause_toggle_r & (dim_cnt_r >= DIM_LIMIT);
      if (!pause_toggle_r) begin
        dim_cnt_r <= 28'd0;
      end else if (dim_cnt_r < DIM_LIMIT) begin
        dim_cnt_r <= dim_cnt_r + 28'd1;
      end
    end
  end

  // Work-RAM arbiter: settle the paused CPU, wait for vblank, grant, then
  // hold pause one extra cycle on release so the RAM mux returns first.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_r      <= ST_RUN;
      settle_cnt_r <= 4'd0;
      hs_grant_r   <= 1'b0;
      ram_sel_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          hs_grant_r <= 1'b0;
          ram_sel_r  <= 1'b0;
          if (hs_req) begin
            state_r      <= ST_WAIT;
            settle_cnt_r <= SETTLE_INIT;
          end
        end
        ST_WAIT: begin
          if (!hs_req) begin
            state_r    <= ST_RUN;
            hs_grant_r <= 1'b0;
            ram_sel_r  <= 1'b0;
          end else if (settle_cnt_r != 4'd0) begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end else if (vblank) begin
            state_r    <= ST_GRANT;
            hs_grant_r <= 1'b1;
            ram_sel_r  <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_GRANT: begin
          if (!hs_req) begin
            state_r    <= ST_RELEASE;
            hs_grant_r <= 1'b0;
            ram_sel_r  <= 1'b0;
          end else begin
            hs_grant_r <= 1'b1;
            ram_sel_r  <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state_r    <= ST_RUN;
          hs_grant_r <= 1'b0;
          ram_sel_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_RUN;
          hs_grant_r <= 1'b0;
          ram_sel_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pause_arbiter.sv
// tb_pause_arbiter: table vectors, directed corner sequences and a random
// run compared against a behavioural model of the pause/arbitration rules.
`timescale 1ns/1ps
module tb_pause_arbiter;

  localparam int DIM    = 100;
  localparam int SETTLE = 4;

  logic clk_sys = 1'b0;
  logic reset_n, user_pause, osd_open, osd_pause_en, vblank, hs_req;
  logic hs_grant, ram_sel, pause, dim;

  int vectors     = 0;
  int miscompares = 0;

  pause_arbiter #(.DIM_CYCLES(DIM), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .user_pause(user_pause),
    .osd_open(osd_open), .osd_pause_en(osd_pause_en), .vblank(vblank),
    .hs_req(hs_req), .hs_grant(hs_grant), .ram_sel(ram_sel),
    .pause(pause), .dim(dim)
  );

  always #5 clk_sys = ~clk_sys;

  // Behavioural model: toggle parity, time spent user-paused, and an
  // arbitration episode tracked as "engaged / cycles held / granted".
  bit m_toggle, m_btn_d, m_dim, m_engaged, m_grant, m_release;
  int m_age, m_held;

  function automatic void model_step();
    bit rise, n_dim;
    if (!reset_n) begin
      m_toggle = 0; m_btn_d = 0; m_dim = 0; m_age = 0;
      m_engaged = 0; m_grant = 0; m_release = 0; m_held = 0;
      return;
    end
    rise  = user_pause && !m_btn_d;
    n_dim = m_toggle && (m_age >= DIM);
    m_age = m_toggle ? m_age + 1 : 0;
    m_toggle = m_toggle ^ rise;
    m_btn_d  = user_pause;
    m_dim    = n_dim;
    if (m_release) begin
      m_release = 0; m_engaged = 0;
    end else if (!m_engaged) begin
      if (hs_req) begin m_engaged = 1; m_held = 0; end
    end else if (m_grant) begin
      if (!hs_req) begin m_grant = 0; m_release = 1; end
    end else if (!hs_req) begin
      m_engaged = 0;
    end else begin
      m_held++;
      if (m_held > SETTLE && vblank) m_grant = 1;
    end
  endfunction

  function automatic bit model_pause();
    return m_toggle | (osd_open & osd_pause_en) | m_engaged;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pause"},    pause,    model_pause());
    chk({tag, ".hs_grant"}, hs_grant, m_grant);
    chk({tag, ".ram_sel"},  ram_sel,  m_grant);
    chk({tag, ".dim"},      dim,      m_dim);
  endtask

  task automatic set_in(input logic r, b, o, e, v, q);
    reset_n = r; user_pause = b; osd_open = o; osd_pause_en = e;
    vblank = v; hs_req = q;
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 2 ns later.
  task automatic cyc();
    @(posedge clk_sys);
    model_step();
    #2;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  typedef struct {
    int   n;
    logic r, b, o, e, v, q;
    logic e_pause, e_grant, e_dim;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input logic r, b, o, e, v, q,
                              input logic ep, eg, ed);
    vec_t t;
    t.n = n; t.r = r; t.b = b; t.o = o; t.e = e; t.v = v; t.q = q;
    t.e_pause = ep; t.e_grant = eg; t.e_dim = ed;
    tbl.push_back(t);
  endfunction

  initial begin
    set_in(0, 0, 0, 0, 0, 0);

    // ---------------- table-driven vectors ----------------
    //   n  rst btn osd en vb req   pause grant dim
    add(2, 0, 0, 0, 0, 0, 0,   0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,   1, 0, 0);
    add(4, 1, 1, 0, 0, 0, 0,   1, 0, 0);
    add(5, 1, 0, 0, 0, 0, 0,   1, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,   0, 0, 0);
    add(4, 1, 1, 0, 0, 0, 0,   0, 0, 0);
    add(5, 1, 0, 0, 0, 0, 0,   0, 0, 0);
    add(3, 1, 0, 1, 0, 0, 0,   0, 0, 0);
    add(3, 1, 0, 1, 1, 0, 0,   1, 0, 0);
    add(2, 1, 0, 0, 1, 0, 0,   0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0,   0, 0, 0);
    foreach (tbl[i]) begin
      set_in(tbl[i].r, tbl[i].b, tbl[i].o, tbl[i].e, tbl[i].v, tbl[i].q);
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc();
        chk($sformatf("tbl%0d.pause", i), pause, tbl[i].e_pause);
        chk($sformatf("tbl%0d.grant", i), hs_grant, tbl[i].e_grant);
        chk($sformatf("tbl%0d.ram_sel", i), ram_sel, tbl[i].e_grant);
        chk($sformatf("tbl%0d.dim", i), dim, tbl[i].e_dim);
      end
    end

    // OSD pause is combinational: no clock edge between change and check.
    osd_pause_en = 1'b1; #1;
    chk("osd_comb_on", pause, 1'b1);
    osd_pause_en = 1'b0; #1;
    chk("osd_comb_off", pause, 1'b0);
    osd_open = 1'b0;

    // ---------------- dim after DIM cycles, cleared by next press ----------
    do_reset();
    user_pause = 1'b1; cyc(); user_pause = 1'b0;
    chk("dim.pause", pause, 1'b1);
    for (int k = 1; k <= DIM + 1; k++) begin
      cyc();
      if (k == DIM) chk("dim.before", dim, 1'b0);
      if (k == DIM + 1) chk("dim.at", dim, 1'b1);
    end
    repeat (20) cyc();
    chk("dim.held", dim, 1'b1);
    user_pause = 1'b1; cyc(); user_pause = 1'b0;
    chk("dim.unpause", pause, 1'b0);
    cyc();
    chk("dim.cleared", dim, 1'b0);

    // ---------------- grant latency with vblank already high ----------------
    do_reset();
    vblank = 1'b1; hs_req = 1'b1;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      cyc();
      chk("lat.pause", pause, 1'b1);
      chk($sformatf("lat.grant@%0d", k), hs_grant, (k == SETTLE + 2) ? 1'b1 : 1'b0);
      chk($sformatf("lat.ram_sel@%0d", k), ram_sel, (k == SETTLE + 2) ? 1'b1 : 1'b0);
    end
    vblank = 1'b0; user_pause = 1'b1;
    repeat (3) cyc();
    user_pause = 1'b0;
    repeat (3) cyc();
    chk("lat.hold_grant", hs_grant, 1'b1);
    user_pause = 1'b1; cyc(); user_pause = 1'b0;
    hs_req = 1'b0; cyc();
    chk("rel.grant", hs_grant, 1'b0);
    chk("rel.ram_sel", ram_sel, 1'b0);
    chk("rel.pause", pause, 1'b1);
    cyc();
    chk("run.pause", pause, 1'b0);

    // ---------------- vblank arrives 50 cycles late ----------------
    do_reset();
    hs_req = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      chk("late.no_grant", hs_grant, 1'b0);
    end
    vblank = 1'b1; cyc();
    chk("late.grant", hs_grant, 1'b1);
    vblank = 1'b0; hs_req = 1'b0; cyc(); cyc();

    // ---------------- abort from WAIT ----------------
    do_reset();
    hs_req = 1'b1;
    repeat (8) begin cyc(); chk("abort.no_grant", hs_grant, 1'b0); end
    hs_req = 1'b0; vblank = 1'b1; cyc();
    chk("abort.grant", hs_grant, 1'b0);
    chk("abort.pause", pause, 1'b0);
    repeat (3) begin cyc(); chk("abort.idle", ram_sel, 1'b0); end

    // ---------------- reset asserted while granted ----------------
    do_reset();
    user_pause = 1'b1; cyc(); user_pause = 1'b0;
    hs_req = 1'b1; vblank = 1'b1;
    repeat (SETTLE + 2) cyc();
    chk("rstg.granted", hs_grant, 1'b1);
    reset_n = 1'b0; cyc();
    chk("rstg.grant", hs_grant, 1'b0);
    chk("rstg.ram_sel", ram_sel, 1'b0);
    chk("rstg.pause", pause, 1'b0);
    reset_n = 1'b1; cyc();
    chk("rstg.rewait", pause, 1'b1);
    repeat (SETTLE + 1) cyc();
    chk("rstg.regrant", hs_grant, 1'b1);
    hs_req = 1'b0; cyc(); cyc();

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(19, 0) == 0) user_pause = ~user_pause;
      if ($urandom_range(14, 0) == 0) hs_req = ~hs_req;
      if ($urandom_range(9, 0) == 0) vblank = ~vblank;
      if ($urandom_range(29, 0) == 0) osd_open = ~osd_open;
      if ($urandom_range(29, 0) == 0) osd_pause_en = ~osd_pause_en;
      reset_n = ($urandom_range(499, 0) != 0);
      cyc();
      chk_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
